// File: rtl/crc_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_link_pkg
//  Description : Shared state encoding and default widths for the CRC link
//                arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_link_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MSG   = 3'd2,
        CRC   = 3'd3,
        GAP   = 3'd4
    } link_state_t;

    localparam int MSG_W_DEF = 11;
    localparam int CRC_W_DEF = 5;

    // Counter must hold the largest per-state cycle index; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin search for the first set request
//                bit at or after the pointer, wrapping cyclically.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import crc_link_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_winner;
    logic             w_valid;

    always_comb begin
        w_winner = '0;
        w_valid  = 1'b0;
        w_sum    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_valid && i_req[w_sum[IDX_W-1:0]]) begin
                w_valid  = 1'b1;
                w_winner = w_sum[IDX_W-1:0];
            end
        end
    end

    assign o_winner = w_winner;
    assign o_valid  = w_valid;

endmodule
`default_nettype wire

// File: rtl/crc_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : crc_link_arbiter
//  Description : Round-robin owner of a serial CRC-5 sender; clears the
//                sender, shifts the granted message out MSB-first, then waits
//                out the CRC tail and inter-frame gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_link_arbiter
    import crc_link_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = MSG_W_DEF,
    parameter int CRC_W   = CRC_W_DEF,
    parameter int GAP_CYC = 2
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*MSG_W-1:0]   msg,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       snd_rst_n,
    output logic                       snd_bit,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(MSG_W, CRC_W, GAP_CYC);

    link_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [MSG_W-1:0]   r_latch;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_snd_rst_n;
    logic               r_snd_bit;
    logic               r_busy;
    logic               r_frame_done;

    logic [IDX_W-1:0]   w_winner;
    logic               w_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_latch      <= '0;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_ack        <= '0;
            r_snd_rst_n  <= 1'b0;
            r_snd_bit    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_ack        <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy      <= 1'b0;
                    r_snd_rst_n <= 1'b1;
                    r_snd_bit   <= 1'b0;
                    // After reset the sender sees one released cycle before a grant.
                    if (w_valid && r_snd_rst_n) begin
                        r_latch     <= msg[w_winner*MSG_W +: MSG_W];
                        r_grant     <= w_winner;
                        r_ptr       <= (w_winner == IDX_W'(NUM_REQ-1)) ? '0 : w_winner + IDX_W'(1);
                        r_snd_rst_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_snd_rst_n <= 1'b1;
                    r_snd_bit   <= r_latch[MSG_W-1];
                    r_latch     <= {r_latch[MSG_W-2:0], 1'b0};
                    r_cnt       <= '0;
                    r_state     <= MSG;
                end
                MSG: begin
                    // Latch shifts left so its MSB is always the next bit to send.
                    if (r_cnt == CNT_W'(MSG_W-1)) begin
                        r_snd_bit <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= CRC;
                    end else begin
                        r_snd_bit <= r_latch[MSG_W-1];
                        r_latch   <= {r_latch[MSG_W-2:0], 1'b0};
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end
                CRC: begin
                    if (r_cnt == CNT_W'(CRC_W-1)) begin
                        r_ack[r_grant] <= 1'b1;
                        r_frame_done   <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYC-1)) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign snd_rst_n  = r_snd_rst_n;
    assign snd_bit    = r_snd_bit;
    assign busy       = r_busy;
    assign grant_id   = r_grant;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_crc_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_link_arbiter
//  Description : Scenario bench for crc_link_arbiter with queued expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_link_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MSG_W   = 11;

    logic                     ck = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*MSG_W-1:0] msg;
    logic [NUM_REQ-1:0]       ack;
    logic                     snd_rst_n;
    logic                     snd_bit;
    logic                     busy;
    logic [1:0]               grant_id;
    logic                     frame_done;

    int errors = 0;
    int checks = 0;

    logic exp_bits[$];
    int   exp_gnt[$];
    int   exp_clr[$];
    int   exp_ack[$];

    crc_link_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MSG_W   (MSG_W),
        .CRC_W   (5),
        .GAP_CYC (2)
    ) dut (
        .ck         (ck),
        .rst        (rst),
        .req        (req),
        .msg        (msg),
        .ack        (ack),
        .snd_rst_n  (snd_rst_n),
        .snd_bit    (snd_bit),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Leaves the DUT in a ready IDLE cycle, which becomes cycle 0 of a test.
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_msg(input logic [MSG_W-1:0] m);
        for (int i = MSG_W-1; i >= 0; i--) exp_bits.push_back(m[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; msg = '0;
        tick(); tick();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (snd_rst_n !== 1'b0) begin errors++; $display("FAIL reset_snd_rst_n: got %b want 0", snd_rst_n); end
        checks++; if (snd_bit !== 1'b0) begin errors++; $display("FAIL reset_snd_bit: got %b want 0", snd_bit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        rst = 1'b0;
        tick();
        checks++; if (snd_rst_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got snd_rst_n=%b busy=%b want 1/0", snd_rst_n, busy);
        end
    endtask

    task automatic test_single();
        logic e;
        do_reset();
        exp_bits.delete();
        msg = '0;
        msg[0*MSG_W +: MSG_W] = 11'b10000001000;
        push_msg(11'b10000001000);
        req = 4'b0001;
        for (int c = 1; c <= 22; c++) begin
            tick();
            checks++; if (snd_rst_n !== (c != 1)) begin errors++; $display("FAIL single_snd_rst_n c%0d: got %b want %b", c, snd_rst_n, (c != 1)); end
            if (c >= 2 && c <= 12) begin
                e = exp_bits.pop_front();
                checks++; if (snd_bit !== e) begin errors++; $display("FAIL single_bit c%0d: got %b want %b", c, snd_bit, e); end
            end else if (c >= 13 && c <= 17) begin
                checks++; if (snd_bit !== 1'b0) begin errors++; $display("FAIL single_crc_bit c%0d: got %b want 0", c, snd_bit); end
            end
            checks++; if (ack !== ((c == 18) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_ack c%0d: got %b", c, ack); end
            checks++; if (frame_done !== (c == 18)) begin errors++; $display("FAIL single_frame_done c%0d: got %b want %b", c, frame_done, (c == 18)); end
            checks++; if (busy !== (c <= 19)) begin errors++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, (c <= 19)); end
            if (c == 18) req = '0;
        end
    endtask

    task automatic test_round_robin();
        int cur;
        int e;
        do_reset();
        exp_gnt = '{0, 1, 2, 3};
        exp_clr = '{1, 21, 41, 61};
        exp_ack = '{18, 38, 58, 78};
        cur = 0;
        req = 4'b1111;
        for (int c = 1; c <= 85; c++) begin
            tick();
            if (busy && !snd_rst_n) begin
                e = (exp_clr.size() > 0) ? exp_clr.pop_front() : -1;
                checks++; if (c != e) begin errors++; $display("FAIL rr_clear_cycle: got c%0d want c%0d", c, e); end
                e = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : -1;
                checks++; if (int'(grant_id) != e) begin errors++; $display("FAIL rr_grant: got %0d want %0d", grant_id, e); end
                cur = int'(grant_id);
            end
            if (ack != 4'b0000) begin
                e = (exp_ack.size() > 0) ? exp_ack.pop_front() : -1;
                checks++; if (c != e) begin errors++; $display("FAIL rr_ack_cycle: got c%0d want c%0d", c, e); end
                checks++; if (ack !== (4'b0001 << cur)) begin errors++; $display("FAIL rr_ack_onehot: got %b want %b", ack, 4'b0001 << cur); end
                req[cur] = 1'b0;
            end
        end
        checks++; if (exp_clr.size() != 0 || exp_ack.size() != 0 || req != 4'b0000) begin
            errors++; $display("FAIL rr_timeout: clears left %0d acks left %0d req %b want 0/0/0000", exp_clr.size(), exp_ack.size(), req);
        end
    endtask

    task automatic test_fairness();
        int e;
        int nacks;
        do_reset();
        exp_gnt = '{2, 0, 2};
        nacks = 0;
        req = 4'b0100;
        for (int c = 1; c <= 80 && (exp_gnt.size() > 0 || busy); c++) begin
            tick();
            if (busy && !snd_rst_n) begin
                e = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : -1;
                checks++; if (int'(grant_id) != e) begin errors++; $display("FAIL fair_grant c%0d: got %0d want %0d", c, grant_id, e); end
            end
            if (ack != 4'b0000) begin
                nacks++;
                req[grant_id] = 1'b0;
                if (nacks == 1) req = 4'b0101;
            end
        end
        checks++; if (exp_gnt.size() != 0 || nacks != 3) begin
            errors++; $display("FAIL fair_timeout: grants left %0d acks %0d want 0/3", exp_gnt.size(), nacks);
        end
    endtask

    task automatic test_latch();
        logic e;
        do_reset();
        exp_bits.delete();
        msg = '0;
        msg[1*MSG_W +: MSG_W] = 11'h5A5;
        push_msg(11'h5A5);
        req = 4'b0010;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL latch_grant: got %0d want 1", grant_id); end
            end
            if (c == 4) msg[1*MSG_W +: MSG_W] = 11'h000;
            if (c >= 2 && c <= 12) begin
                e = exp_bits.pop_front();
                checks++; if (snd_bit !== e) begin errors++; $display("FAIL latch_bit c%0d: got %b want %b", c, snd_bit, e); end
            end
            if (c == 18) begin
                checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL latch_ack: got %b want 0010", ack); end
                req = '0;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        msg = '0;
        msg[0*MSG_W +: MSG_W] = 11'h3C3;
        req = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 7) rst = 1'b1;
            if (c == 8) begin
                checks++; if (snd_rst_n !== 1'b0 || busy !== 1'b0 || snd_bit !== 1'b0 || grant_id !== 2'd0 || frame_done !== 1'b0) begin
                    errors++; $display("FAIL mid_reset_outputs: got snd_rst_n=%b busy=%b bit=%b gid=%0d fd=%b want 0/0/0/0/0", snd_rst_n, busy, snd_bit, grant_id, frame_done);
                end
                rst = 1'b0;
            end
            if (c == 9) begin
                checks++; if (snd_rst_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got snd_rst_n=%b busy=%b want 1/0", snd_rst_n, busy); end
            end
            if (c == 10) begin
                checks++; if (snd_rst_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset_clear: got snd_rst_n=%b busy=%b want 0/1", snd_rst_n, busy); end
            end
            checks++; if (ack !== ((c == 27) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL mid_reset_ack c%0d: got %b", c, ack); end
            if (c == 27) req = '0;
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        msg = '0;
        msg[0*MSG_W +: MSG_W] = 11'h7FF;
        req = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 5) req = '0;
            checks++; if (ack !== ((c == 18) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL drop_ack c%0d: got %b", c, ack); end
            if (c >= 20) begin
                checks++; if (busy !== 1'b0 || snd_rst_n !== 1'b1) begin errors++; $display("FAIL drop_no_regrant c%0d: got busy=%b snd_rst_n=%b want 0/1", c, busy, snd_rst_n); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        msg = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_latch();
        test_reset_mid();
        test_drop_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_link_arbiter.md
Name: crc_link_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one serial CRC-5 sender (11-bit message + 5-bit CRC frame) between NUM_REQ requesters.
- Grants one requester at a time and captures its parallel message.
- Drives the sender's active-low reset and serial message input MSB-first, then waits out the CRC tail and an inter-frame gap.
- Sits between the message sources and the link sender; no CRC arithmetic is done here.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MSG_W, 11, message bits per frame
CRC_W, 5, CRC tail bits emitted by the sender after the message
GAP_CYC, 2, idle cycles between frames (>=1)

Ports:
ck  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester frame request; held until ack
msg  in  NUM_REQ*MSG_W  requester i message at bits [i*MSG_W +: MSG_W]
ack  out  NUM_REQ  one-cycle pulse to granted requester when its frame is complete
snd_rst_n  out  1  active-low reset to sender/CRC datapath
snd_bit  out  1  serial message bit to sender
busy  out  1  high from CLEAR through end of GAP
grant_id  out  clog2(NUM_REQ)  index of current owner; valid while busy
frame_done  out  1  one-cycle pulse, same cycle as ack

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ack=0, snd_rst_n=0, snd_bit=0, busy=0, grant_id=0, frame_done=0, rr pointer=0, counter=0, message latch=0.
- rst asserted mid-frame: the frame is aborted next edge with no ack, and outputs return to reset values. snd_rst_n stays low while rst is high, so the sender is also cleared.
- States and transitions:
  - IDLE: snd_rst_n=1, busy=0.
    - If any req bit is set, pick the first set bit at or after the rr pointer, cyclically.
    - Latch its msg slice and set grant_id to the winner.
    - Set rr pointer to (winner+1) mod NUM_REQ, then go to CLEAR.
    - If req==0, stay in IDLE.
  - CLEAR, 1 cycle: snd_rst_n=0, busy=1, then go to MSG with counter=0.
  - MSG, MSG_W cycles: snd_rst_n=1 and snd_bit=latch[MSG_W-1-counter], i.e. MSB first. Counter increments each cycle; at counter==MSG_W-1 go to CRC with counter=0.
  - CRC, CRC_W cycles: snd_bit=0 because the sender drives its own tail. At counter==CRC_W-1 go to GAP with counter=0.
  - GAP, GAP_CYC cycles: ack[grant_id]=1 and frame_done=1 in the first GAP cycle only. busy stays 1. At counter==GAP_CYC-1 go to IDLE.
- Timing, with req first sampled in IDLE at cycle 0:
  - CLEAR at cycle 1.
  - MSG at cycles 2..MSG_W+1.
  - CRC at cycles MSG_W+2..MSG_W+CRC_W+1.
  - ack at cycle MSG_W+CRC_W+2.
  - IDLE again at cycle MSG_W+CRC_W+GAP_CYC+2.
  - With defaults: CLEAR c1, MSG c2..c12, CRC c13..c17, ack c18, IDLE c20, next CLEAR c21.
- The message is latched at grant. Changes to msg or req during a frame do not affect it.
- req dropped mid-frame: the frame still completes and ack still pulses.
- req still high in the first IDLE cycle after ack counts as a new request. Requesters deassert req on ack.
- Simultaneous requests resolve by the rr pointer only. No requester waits more than NUM_REQ-1 frames.
- Counter width is clog2(max(MSG_W,CRC_W,GAP_CYC)). Counters wrap only through the state transitions above.
- At most one ack bit is ever high.

Decomposition:
- Package crc_link_pkg holds:
  - enum link_state_t {IDLE, CLEAR, MSG, CRC, GAP};
  - default constants MSG_W_DEF=11, CRC_W_DEF=5.
- Sub-module rr_picker: combinational round-robin first-set-bit search. Inputs are req and the rr pointer; outputs are winner index and valid.
- The FSM, counter, message latch and output registers stay in crc_link_arbiter.

Test Plan:
- Single request: req=4'b0001, msg0=11'b10000001000.
  - snd_rst_n low at c1 only.
  - snd_bit c2..c12 = 1,0,0,0,0,0,0,1,0,0,0.
  - ack=4'b0001 and frame_done at c18; busy low from c20.
- All four request at c0, req held and dropped at each ack.
  - grant_id sequence is 0,1,2,3.
  - Acks at c18, c38, c58, c78; CLEAR cycles at c1, c21, c41, c61.
- Pointer fairness: grant req2 alone, then assert req=4'b0101.
  - Next grant is 0 (pointer=3 wraps to 0), then 2.
- Message latch: msg1 changes from 11'h5A5 to 11'h000 during the MSG state.
  - snd_bit stream still equals 11'h5A5 MSB-first (1,0,1,1,0,1,0,0,1,0,1).
- Reset mid-frame: rst high at c7 for one cycle.
  - Outputs at reset values at c8 (snd_rst_n=0) and no ack.
  - With req0 still held, a fresh frame starts with CLEAR at c10.
- Drop req: req0 deasserted at c5.
  - ack[0] still pulses at c18; no further grant follows.
